// File: rtl/pong_game_ctrl_if.sv
// Game-event and score/overlay signals between the pong graphics side and the game sequencer.
// master drives frame/button/collision inputs and score digits; slave is the sequencer.
interface pong_game_ctrl_if #(
  parameter int BW = 3
) ();
  logic          refresh_tick;
  logic [1:0]    btn;
  logic          hit;
  logic          miss;
  logic [3:0]    dig0;
  logic [3:0]    dig1;
  logic          d_inc;
  logic          d_clr;
  logic          gra_still;
  logic [1:0]    text_sel;
  logic [BW-1:0] balls_left;
  logic          timer_busy;

  modport master (
    output refresh_tick, btn, hit, miss, dig0, dig1,
    input  d_inc, d_clr, gra_still, text_sel, balls_left, timer_busy
  );

  modport slave (
    input  refresh_tick, btn, hit, miss, dig0, dig1,
    output d_inc, d_clr, gra_still, text_sel, balls_left, timer_busy
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: score strobes, ball count, frame-based pause timer, overlay select.
// Optional PONG_WIN_CAP_EN: a hit at score 99 ends the game instead of wrapping the counter.
module pong_game_ctrl #(
  parameter int BALLS       = 3,
  parameter int TIMER_TICKS = 120,
  parameter int BW          = 3
) (
  input  logic            clk,
  input  logic            reset,
  pong_game_ctrl_if.slave bus
);
  typedef enum logic [1:0] {NEWGAME, PLAY, NEWBALL, OVER} state_e;

  localparam logic [7:0]    TLOAD      = 8'(TIMER_TICKS - 1);
  localparam logic [BW-1:0] BALLS_INIT = BW'(BALLS);

  state_e        state_q, state_d;
  logic [7:0]    timer_q, timer_d;
  logic [BW-1:0] balls_q, balls_d;
  logic          btn_prev_q;
  logic          d_inc_q, d_inc_d;
  logic          d_clr_q, d_clr_d;
  logic          gra_still_q;
  logic [1:0]    text_sel_q, text_sel_d;
  logic          timer_busy_q;
  logic          start;
  logic          at_cap;

  // A held button only counts once: edge against last cycle's level.
  assign start = (|bus.btn) & ~btn_prev_q;

`ifdef PONG_WIN_CAP_EN
  assign at_cap = (bus.dig1 == 4'd9) && (bus.dig0 == 4'd9);
`else
  logic unused_dig;
  assign unused_dig = ^{bus.dig1, bus.dig0};
  assign at_cap     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    balls_d = balls_q;
    d_inc_d = 1'b0;
    d_clr_d = 1'b0;
    if (bus.refresh_tick && (timer_q != 8'd0)) timer_d = timer_q - 8'd1;
    case (state_q)
      NEWGAME: begin
        balls_d = BALLS_INIT;
        if (start) begin
          d_clr_d = 1'b1;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (bus.hit && at_cap) begin
          state_d = OVER;
          timer_d = TLOAD;
        end else begin
          d_inc_d = bus.hit;
          if (bus.miss) begin
            timer_d = TLOAD;
            if (balls_q > BW'(1)) begin
              balls_d = balls_q - BW'(1);
              state_d = NEWBALL;
            end else begin
              balls_d = '0;
              state_d = OVER;
            end
          end
        end
      end
      NEWBALL: if (start && (timer_q == 8'd0)) state_d = PLAY;
      OVER: begin
        if (timer_q == 8'd0) begin
          state_d = NEWGAME;
          balls_d = BALLS_INIT;
        end
      end
      default: state_d = NEWGAME;
    endcase
  end

  always_comb begin
    text_sel_d = 2'b01;
    case (state_d)
      NEWGAME: text_sel_d = 2'b01;
      PLAY:    text_sel_d = 2'b00;
      NEWBALL: text_sel_d = 2'b11;
      OVER:    text_sel_d = 2'b10;
      default: text_sel_d = 2'b01;
    endcase
  end

  // Overlay/freeze/busy are registered from next-state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= NEWGAME;
      timer_q      <= 8'd0;
      balls_q      <= BALLS_INIT;
      btn_prev_q   <= 1'b0;
      d_inc_q      <= 1'b0;
      d_clr_q      <= 1'b0;
      gra_still_q  <= 1'b1;
      text_sel_q   <= 2'b01;
      timer_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      balls_q      <= balls_d;
      btn_prev_q   <= |bus.btn;
      d_inc_q      <= d_inc_d;
      d_clr_q      <= d_clr_d;
      gra_still_q  <= (state_d != PLAY);
      text_sel_q   <= text_sel_d;
      timer_busy_q <= (timer_d != 8'd0);
    end
  end

  assign bus.d_inc      = d_inc_q;
  assign bus.d_clr      = d_clr_q;
  assign bus.gra_still  = gra_still_q;
  assign bus.text_sel   = text_sel_q;
  assign bus.balls_left = balls_q;
  assign bus.timer_busy = timer_busy_q;
endmodule
